// File: rtl/rv32_mem_pkg.sv
// Shared encodings, payload types and lane helpers for the RV32 memory-access stage.
package rv32_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [RD_W-1:0] NOP_RD = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } dm_cmd_t;

  // Size/alignment/f3 legality; unsigned sizes are load-only.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic store);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{data[7:0]}};
      2'b01:   d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Extracts the addressed byte/half lane from a read word and sign/zero-extends it.
module lsu_load_fmt
  import rv32_mem_pkg::*;
(
  input  logic [XLEN-1:0] dm_rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] load_val
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = dm_rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (f3)
      F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_val = {24'd0, byte_lane};
      F3_HU:   load_val = {16'd0, half_lane};
      default: load_val = dm_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory port, store lane formatting, load
// alignment/extension, registered writeback and a timeout on hung transactions.
module mem_stage
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] d_add,
  input  logic            d_r_en,
  input  logic            d_w_en,
  input  logic [2:0]      f3,
  input  logic [RD_W-1:0] alu_rd,
  input  logic            alu_reg_w_en,
  output logic            mem_busy,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_be,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mis_align,
  output logic            bus_err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  dm_cmd_t         cmd, cmd_d;
  logic            req_d;
  logic [1:0]      lo_q, lo_d;
  logic [2:0]      f3_q, f3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            wb_en_d, mis_d, berr_d;
  logic [RD_W-1:0] wb_rd_d;
  logic [XLEN-1:0] wb_data_d;
  logic [XLEN-1:0] load_val;
  logic            last_cycle;

  lsu_load_fmt u_load_fmt (
    .dm_rdata (dm_rdata),
    .addr_lo  (lo_q),
    .f3       (f3_q),
    .load_val (load_val)
  );

  assign last_cycle = (cnt == TO_LAST);
  // Upstream may advance on the ack edge and on the timeout edge.
  assign mem_busy   = (state == WAIT) & ~dm_ack & ~last_cycle;

  assign dm_we    = cmd.we;
  assign dm_addr  = cmd.addr;
  assign dm_wdata = cmd.wdata;
  assign dm_be    = cmd.be;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cmd_d     = cmd;
    req_d     = dm_req;
    lo_d      = lo_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd;
    wb_data_d = wb_data;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_r_en || d_w_en) begin
          if (access_legal(f3, d_add[1:0], d_w_en)) begin
            state_d     = WAIT;
            cnt_d       = '0;
            req_d       = 1'b1;
            cmd_d.we    = d_w_en;
            cmd_d.addr  = {d_add[31:2], 2'b00};
            cmd_d.be    = lane_be(f3, d_add[1:0]);
            cmd_d.wdata = store_lanes(f3, alu_out);
            lo_d        = d_add[1:0];
            f3_d        = f3;
            rd_d        = alu_rd;
          end else begin
            mis_d = 1'b1;
          end
        end else if (alu_reg_w_en && (alu_rd != NOP_RD)) begin
          wb_en_d   = 1'b1;
          wb_rd_d   = alu_rd;
          wb_data_d = alu_out;
        end
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (dm_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (!cmd.we && (rd_q != NOP_RD)) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = load_val;
          end
        end else if (last_cycle) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      dm_req    <= 1'b0;
      lo_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mis_align <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cmd       <= cmd_d;
      dm_req    <= req_d;
      lo_q      <= lo_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      wb_en     <= wb_en_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      mis_align <= mis_d;
      bus_err   <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out, d_add, dm_rdata;
  logic        d_r_en, d_w_en, alu_reg_w_en, dm_ack;
  logic [2:0]  f3;
  logic [4:0]  alu_rd;
  logic        mem_busy, dm_req, dm_we, wb_en, mis_align, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_data;
  logic [3:0]  dm_be;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;
  bit hang  = 1'b0;

  mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .d_add(d_add), .d_r_en(d_r_en),
    .d_w_en(d_w_en), .f3(f3), .alu_rd(alu_rd), .alu_reg_w_en(alu_reg_w_en),
    .mem_busy(mem_busy), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .mis_align(mis_align),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_txn = 1'b0;
  int unsigned m_waited = 0;
  logic [1:0]  m_lo = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_rd = '0;
  logic        e_req = 1'b0, e_we = 1'b0, e_wb_en = 1'b0, e_mis = 1'b0, e_berr = 1'b0;
  logic        e_busy = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_wb_data = '0;
  logic [3:0]  e_be = '0;
  logic [4:0]  e_wb_rd = '0;

  function automatic int unsigned nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit legal_m(input logic [2:0] f, input logic [31:0] a, input bit st);
    bit ok_f3;
    ok_f3 = st ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return ok_f3 && ((a % nbytes(f)) == 0);
  endfunction

  function automatic logic [3:0] be_m(input logic [2:0] f, input logic [31:0] a);
    int unsigned mask;
    mask = ((1 << nbytes(f)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] wdata_m(input logic [2:0] f, input logic [31:0] d);
    case (nbytes(f))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] rd, input logic [1:0] lo,
                                         input logic [2:0] f);
    logic [31:0] v;
    int sh;
    v = rd >> (8 * lo);
    if (nbytes(f) < 4) begin
      sh = 32 - 8 * int'(nbytes(f));
      if (f[2]) v = (v << sh) >> sh;
      else      v = 32'($signed(v << sh) >>> sh);
    end
    return v;
  endfunction

  // Predicts the registered outputs after the coming rising edge.
  always begin
    @(negedge clk); #1;
    e_wb_en = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    if (!rst) begin
      m_txn = 1'b0; m_waited = 0; e_busy = 1'b0;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      e_wb_rd = '0; e_wb_data = '0;
    end else if (!m_txn) begin
      e_busy = 1'b0;
      if (d_r_en || d_w_en) begin
        if (legal_m(f3, d_add, d_w_en)) begin
          m_txn = 1'b1; m_waited = 0;
          e_req = 1'b1; e_we = d_w_en;
          e_addr = d_add & ~32'd3;
          e_be = be_m(f3, d_add);
          e_wdata = wdata_m(f3, alu_out);
          m_lo = d_add[1:0]; m_f3 = f3; m_rd = alu_rd;
        end else begin
          e_mis = 1'b1;
        end
      end else if (alu_reg_w_en && alu_rd != 5'd0) begin
        e_wb_en = 1'b1; e_wb_rd = alu_rd; e_wb_data = alu_out;
      end
    end else begin
      e_busy = !dm_ack && (m_waited + 1 < TO);
      if (dm_ack) begin
        m_txn = 1'b0; e_req = 1'b0;
        if (!e_we && m_rd != 5'd0) begin
          e_wb_en = 1'b1; e_wb_rd = m_rd; e_wb_data = load_m(dm_rdata, m_lo, m_f3);
        end
      end else if (m_waited + 1 == TO) begin
        m_txn = 1'b0; e_req = 1'b0; e_berr = 1'b1;
      end else begin
        m_waited++;
      end
    end
  end

  // Compare process: mem_busy mid-cycle, registered outputs after each edge.
  always begin
    @(negedge clk); #2;
    chk("mem_busy", 32'(mem_busy), 32'(e_busy));
    @(posedge clk); #2;
    chk("dm_req", 32'(dm_req), 32'(e_req));
    chk("wb_en", 32'(wb_en), 32'(e_wb_en));
    chk("mis_align", 32'(mis_align), 32'(e_mis));
    chk("bus_err", 32'(bus_err), 32'(e_berr));
    if (e_req) begin
      chk("dm_we", 32'(dm_we), 32'(e_we));
      chk("dm_addr", dm_addr, e_addr);
      chk("dm_be", 32'(dm_be), 32'(e_be));
      if (e_we) chk("dm_wdata", dm_wdata, e_wdata);
    end
    if (e_wb_en) begin
      chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
      chk("wb_data", wb_data, e_wb_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    d_r_en = 1'b0; d_w_en = 1'b0; alu_reg_w_en = 1'b0; dm_ack = 1'b0;
    alu_out = $urandom; d_add = $urandom; f3 = 3'($urandom_range(0, 7));
    alu_rd = 5'($urandom_range(0, 31));
  endtask

  task automatic issue(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] data, input logic [4:0] rd);
    d_r_en = r; d_w_en = w; f3 = f; d_add = a; alu_out = data; alu_rd = rd;
    alu_reg_w_en = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 9);
    d_r_en = (k <= 3) || (k == 7);
    d_w_en = (k >= 4) && (k <= 7);
    alu_reg_w_en = (k == 8) || ($urandom_range(0, 3) == 0);
    f3 = 3'($urandom_range(0, 7));
    d_add = $urandom;
    if ($urandom_range(0, 1) == 1) d_add[1:0] = 2'b00;
    alu_out = $urandom;
    alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endtask

  initial begin
    int req_cnt, berr_cnt, wb_cnt, busy_cnt;
    rst = 1'b0;
    drive_idle();
    dm_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_busy", 32'(mem_busy), 32'd0);
    rst = 1'b1;

    // SB 0xA5 to 0x103
    @(negedge clk); issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd9);
    @(posedge clk); #2;
    chk("sb_req", 32'(dm_req), 32'd1);
    chk("sb_we", 32'(dm_we), 32'd1);
    chk("sb_be", 32'(dm_be), 32'b1000);
    chk("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", dm_addr, 32'h100);
    @(negedge clk); drive_idle(); dm_ack = 1'b1; #2;
    chk("sb_busy_ack", 32'(mem_busy), 32'd0);
    @(posedge clk); #2;
    chk("sb_req_drop", 32'(dm_req), 32'd0);
    chk("sb_no_wb", 32'(wb_en), 32'd0);

    // LB / LBU at 0x202, zero-wait memory
    for (int u = 0; u < 2; u++) begin
      @(negedge clk); issue(1'b1, 1'b0, (u == 0) ? 3'b000 : 3'b100, 32'h202, 32'h0, 5'd5);
      @(posedge clk); #2;
      chk("lb_req", 32'(dm_req), 32'd1);
      chk("lb_be", 32'(dm_be), 32'b0100);
      @(negedge clk); drive_idle(); dm_ack = 1'b1; dm_rdata = 32'h12F0_3456;
      @(posedge clk); #2;
      chk("lb_wb_en", 32'(wb_en), 32'd1);
      chk("lb_wb_rd", 32'(wb_rd), 32'd5);
      chk("lb_wb_data", wb_data, (u == 0) ? 32'hFFFF_FFF0 : 32'h0000_00F0);
    end

    // LH misaligned
    @(negedge clk); issue(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 5'd4); #2;
    chk("lh_mis_busy", 32'(mem_busy), 32'd0);
    @(posedge clk); #2;
    chk("lh_mis_pulse", 32'(mis_align), 32'd1);
    chk("lh_mis_noreq", 32'(dm_req), 32'd0);
    @(negedge clk); drive_idle();
    @(posedge clk); #2;
    chk("lh_mis_once", 32'(mis_align), 32'd0);
    chk("lh_mis_noreq2", 32'(dm_req), 32'd0);

    // LW with no ack: timeout
    @(negedge clk); issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd7);
    req_cnt = 0; berr_cnt = 0; wb_cnt = 0;
    @(posedge clk); #2;
    for (int i = 0; i < 22; i++) begin
      req_cnt += int'(dm_req); berr_cnt += int'(bus_err); wb_cnt += int'(wb_en);
      @(negedge clk); drive_idle();
      @(posedge clk); #2;
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd16);
    chk("to_berr_pulses", 32'(berr_cnt), 32'd1);
    chk("to_no_wb", 32'(wb_cnt), 32'd0);

    // Pass-through rd=3 then rd=0
    @(negedge clk); drive_idle(); alu_reg_w_en = 1'b1; alu_rd = 5'd3; alu_out = 32'h7;
    @(posedge clk); #2;
    chk("pt_wb_en", 32'(wb_en), 32'd1);
    chk("pt_wb_rd", 32'(wb_rd), 32'd3);
    chk("pt_wb_data", wb_data, 32'h7);
    @(negedge clk); alu_rd = 5'd0;
    @(posedge clk); #2;
    chk("pt_rd0", 32'(wb_en), 32'd0);

    // LW stalled by 3 wait cycles
    @(negedge clk); issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_idle(); dm_ack = (i == 3); dm_rdata = 32'hCAFE_BABE; #2;
      busy_cnt += int'(mem_busy);
      if (i == 3) chk("st_busy_ack", 32'(mem_busy), 32'd0);
    end
    chk("st_busy_cycles", 32'(busy_cnt), 32'd3);
    @(posedge clk); #2;
    chk("st_wb_en", 32'(wb_en), 32'd1);
    chk("st_wb_data", wb_data, 32'hCAFE_BABE);

    // Async reset mid-WAIT
    @(negedge clk); issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h1234_5678, 5'd9);
    repeat (2) begin @(negedge clk); drive_idle(); end
    @(posedge clk); #3;
    rst = 1'b0; #1;
    chk("ar_dm_req", 32'(dm_req), 32'd0);
    chk("ar_dm_addr", dm_addr, 32'd0);
    chk("ar_dm_wdata", dm_wdata, 32'd0);
    chk("ar_dm_be", 32'(dm_be), 32'd0);
    chk("ar_dm_we", 32'(dm_we), 32'd0);
    chk("ar_wb", 32'(wb_en) | 32'(wb_rd) | wb_data, 32'd0);
    chk("ar_err", 32'(mis_align) | 32'(bus_err) | 32'(mem_busy), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    wb_cnt = 0;
    repeat (6) begin
      @(negedge clk); drive_idle(); dm_ack = 1'(($urandom_range(0, 1)));
      @(posedge clk); #2; wb_cnt += int'(wb_en);
    end
    chk("ar_no_wb_after", 32'(wb_cnt), 32'd0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_instr();
      if (!m_txn) begin
        hang = ($urandom_range(0, 9) == 0);
        dm_ack = ($urandom_range(0, 5) == 0);
      end else begin
        dm_ack = !hang && ($urandom_range(0, 2) == 0);
      end
      dm_rdata = $urandom;
    end
    @(negedge clk); drive_idle();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
